// File: rtl/pci_tx_pkg.sv
// pci_tx_pkg: shared arbiter state encoding, VC identifiers and burst counter width.
package pci_tx_pkg;
  typedef enum logic [1:0] {IDLE, SERVE_VC0, SERVE_VC1} arb_state_e;
  localparam logic VC0_ID = 1'b0;
  localparam logic VC1_ID = 1'b1;
  localparam int CNT_W = 4;
  function automatic arb_state_e serve_state(input logic vc);
    return (vc == VC1_ID) ? SERVE_VC1 : SERVE_VC0;
  endfunction
endpackage

// File: rtl/vc_arb_burst_cnt.sv
// vc_arb_burst_cnt: per-round burst counter; tc flags the pop that exhausts the weight.
module vc_arb_burst_cnt
  import pci_tx_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  input  logic [CNT_W-1:0] weight,
  output logic             tc
);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  always_comb begin
    tc    = (cnt_q + 1'b1) == weight;
    cnt_d = (clr | (inc & tc)) ? '0 : inc ? cnt_q + 1'b1 : cnt_q;
  end
  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
endmodule

// File: rtl/vc_arbiter.sv
// vc_arbiter: VC0/VC1 -> main FIFO scheduler; VC_ARB_WRR_EN selects weighted
// round-robin, otherwise strict VC0 priority.
module vc_arbiter
  import pci_tx_pkg::*;
#(
  parameter int data_width = 6,
  parameter int VC0_WEIGHT = 3,
  parameter int VC1_WEIGHT = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  arb_enable,
  input  logic                  empty_fifo_VC0,
  input  logic                  empty_fifo_VC1,
  input  logic [data_width-1:0] data_out_VC0,
  input  logic [data_width-1:0] data_out_VC1,
  input  logic                  full_main,
  input  logic                  almost_full_main,
  output logic                  rd_enable_VC0,
  output logic                  rd_enable_VC1,
  output logic                  wr_enable_main,
  output logic [data_width-1:0] data_main,
  output logic                  active_vc,
  output logic                  error_arb
);
  if (VC0_WEIGHT < 1 || VC0_WEIGHT > 15 || VC1_WEIGHT < 1 || VC1_WEIGHT > 15)
    $error("vc_arbiter weights must lie in 1..15");
  arb_state_e            state_q, state_d;
  logic                  pending_q, pending_d, pending_vc_q, pending_vc_d;
  logic                  wr_q, wr_d, err_q, err_d;
  logic [data_width-1:0] data_q, data_d;
  logic                  stall, pop0, pop1, pop, cur_vc, oth_empty, tc;
  assign stall     = full_main | almost_full_main | ~arb_enable;
  assign cur_vc    = state_q == SERVE_VC1;
  assign oth_empty = cur_vc ? empty_fifo_VC0 : empty_fifo_VC1;
  assign pop0      = (state_q == SERVE_VC0) & ~empty_fifo_VC0 & ~stall & ~reset;
  assign pop       = pop0 | pop1;
`ifdef VC_ARB_WRR_EN
  logic             cnt_clr;
  logic [CNT_W-1:0] weight;
  assign pop1    = (state_q == SERVE_VC1) & ~empty_fifo_VC1 & ~stall & ~reset;
  assign cnt_clr = ~stall & ((state_q == IDLE) | ~pop);
  assign weight  = cur_vc ? CNT_W'(VC1_WEIGHT) : CNT_W'(VC0_WEIGHT);
  vc_arb_burst_cnt u_burst_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (cnt_clr),
    .inc   (pop),
    .weight(weight),
    .tc    (tc)
  );
`else
  // VC1 yields as soon as VC0 has data; the state then hands over to VC0.
  assign pop1 = (state_q == SERVE_VC1) & ~empty_fifo_VC1 & empty_fifo_VC0 & ~stall & ~reset;
  assign tc   = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    if (!stall)
      state_d = (state_q == IDLE) ? (~empty_fifo_VC0 ? SERVE_VC0 : ~empty_fifo_VC1 ? SERVE_VC1 : IDLE)
              : pop ? ((tc & ~oth_empty) ? serve_state(~cur_vc) : state_q)
              : (oth_empty ? IDLE : serve_state(~cur_vc));
    pending_d    = pop;
    pending_vc_d = pop ? pop1 : pending_vc_q;
    wr_d         = pending_q;
    data_d       = pending_q ? (pending_vc_q ? data_out_VC1 : data_out_VC0) : data_q;
    err_d        = err_q | (wr_q & full_main) | (pop0 & empty_fifo_VC0) | (pop1 & empty_fifo_VC1);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      pending_q    <= 1'b0;
      pending_vc_q <= VC0_ID;
      wr_q         <= 1'b0;
      data_q       <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      pending_q    <= pending_d;
      pending_vc_q <= pending_vc_d;
      wr_q         <= wr_d;
      data_q       <= data_d;
      err_q        <= err_d;
    end
  end
  assign rd_enable_VC0  = pop0;
  assign rd_enable_VC1  = pop1;
  assign wr_enable_main = wr_q;
  assign data_main      = data_q;
  assign active_vc      = cur_vc;
  assign error_arb      = err_q;
endmodule
